// File: rtl/rf_req_encoder_pkg.sv
// Shared register-file package: address/vector widths and types used by the
// request encoder, the write decoder and the register file itself.
package rf_pkg;

  localparam int RF_BITS = 5;
  localparam int RF_REGS = 2 ** RF_BITS;

  typedef logic [RF_BITS-1:0] rf_addr_t;
  typedef logic [RF_REGS-1:0] rf_vec_t;

endpackage : rf_pkg

// File: rtl/rf_req_encoder_if.sv
// Request/issue bus of the register request encoder.
// master: request source plus address consumer; slave: the encoder.
interface rf_req_encoder_if
  import rf_pkg::*;
#(
  parameter int BITS = RF_BITS
);

  logic                 flush;
  logic                 req_valid;
  logic [2**BITS-1:0]   req_vec;
  logic                 out_valid;
  logic [BITS-1:0]      out_addr;
  logic                 out_ready;
  logic [2**BITS-1:0]   pending;
  logic                 busy;

  modport master (
    output flush,
    output req_valid,
    output req_vec,
    output out_ready,
    input  out_valid,
    input  out_addr,
    input  pending,
    input  busy
  );

  modport slave (
    input  flush,
    input  req_valid,
    input  req_vec,
    input  out_ready,
    output out_valid,
    output out_addr,
    output pending,
    output busy
  );

endinterface : rf_req_encoder_if

// File: rtl/rf_req_encoder_rr_pick.sv
// Round-robin picker: rotate the vector so that i_ptr lands at bit 0, take the
// lowest set bit, then add i_ptr back. Purely combinational; also intended for
// the read-port arbiter.
module rr_pick
  import rf_pkg::*;
#(
  parameter int Bits = RF_BITS
) (
  input  logic [2**Bits-1:0] i_vec,
  input  logic [Bits-1:0]    i_ptr,
  output logic [Bits-1:0]    o_idx,
  output logic               o_found
);

  localparam int N = 2 ** Bits;

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [Bits-1:0] w_off;

  assign w_dbl = {i_vec, i_vec} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Lowest set bit of the rotated vector (descending loop so the lowest wins).
  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i[Bits-1:0];
    end
  end

  // Un-rotate; wraps naturally because the register count is a power of two.
  assign o_idx   = w_off + i_ptr;
  assign o_found = |i_vec;

endmodule : rr_pick

// File: rtl/rf_req_encoder.sv
// Register request encoder: accumulates per-register request bits into a
// sticky pending set and issues them one address per cycle over a
// valid/ready handshake, round-robin from the last issued address.
// Optional build macro RF_ZERO_MASK_EN: register 0 is hardwired zero and is
// never accepted into the pending set.
module rf_req_encoder
  import rf_pkg::*;
#(
  parameter int Bits = RF_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_req_encoder_if.slave    bus
);

  localparam int N = 2 ** Bits;

`ifdef RF_ZERO_MASK_EN
  localparam logic [N-1:0] ReqMask = {{(N-1){1'b1}}, 1'b0};
`else
  localparam logic [N-1:0] ReqMask = {N{1'b1}};
`endif

  logic [N-1:0]    r_pending;
  logic            r_out_valid;
  logic [Bits-1:0] r_out_addr;
  logic [Bits-1:0] r_rr_ptr;

  logic            w_fire;
  logic            w_load;
  logic [Bits-1:0] w_pick;
  logic            w_pick_valid;
  logic            w_issue;
  logic [N-1:0]    w_clear_mask;
  logic [N-1:0]    w_req_in;

  rr_pick #(.Bits(Bits)) u_rr_pick (
    .i_vec   (r_pending),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick),
    .o_found (w_pick_valid)
  );

  assign w_fire  = r_out_valid & bus.out_ready;
  assign w_load  = ~r_out_valid | w_fire;
  assign w_issue = w_load & w_pick_valid;

  // One-hot clear of the address being moved into the output register.
  always_comb begin
    w_clear_mask = '0;
    if (w_issue) w_clear_mask[w_pick] = 1'b1;
  end

  // Incoming requests, qualified and optionally stripped of register 0.
  always_comb begin
    w_req_in = '0;
    if (bus.req_valid) w_req_in = bus.req_vec & ReqMask;
  end

  // Pending set, output stage and round-robin pointer. Set is OR-ed after the
  // clear so a re-request of the issuing bit re-pends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_rr_ptr    <= '0;
    end else if (bus.flush) begin
      r_pending   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clear_mask) | w_req_in;
      if (w_load) begin
        if (w_pick_valid) begin
          r_out_addr  <= w_pick;
          r_out_valid <= 1'b1;
          r_rr_ptr    <= w_pick + 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.pending   = r_pending;
  assign bus.busy      = (|r_pending) | r_out_valid;

endmodule : rf_req_encoder

// File: doc/rf_req_encoder.md
Name: rf_req_encoder

Overview:
- Inverse of the register-file write decoder.
- Collects per-register request bits (32 one-hot/multi-hot lines) into a sticky pending set.
- Serialises the pending set into a stream of 5-bit register addresses over a valid/ready handshake, using round-robin priority.
- Sits between scoreboard/writeback request sources and a register-file port that accepts one address per cycle.

Parameters:
- Bits, 5, address width; register count is 2**Bits (32 at default).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of pending set and output register.
- req_valid  input  1  qualifies req_vec this cycle.
- req_vec  input  2**Bits  request bits, any number set.
- out_valid  output  1  out_addr holds a valid encoded address.
- out_addr  output  Bits  encoded register address.
- out_ready  input  1  consumer accepts out_addr this cycle.
- pending  output  2**Bits  current pending set, registered.
- busy  output  1  (|pending) | out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: pending=0, out_valid=0, out_addr=0, rr_ptr=0, busy=0.
- Fire: fire = out_valid & out_ready.
- Output load: out_load = ~out_valid | fire.
- Pick: combinational round-robin search of pending, starting at index rr_ptr upward. Wraps from 2**Bits-1 to 0. pick_valid = |pending.
- On out_load & pick_valid (edge):
  - out_addr <= pick, out_valid <= 1.
  - Clear pending[pick].
  - rr_ptr <= pick+1, modulo 2**Bits.
- On out_load & ~pick_valid: out_valid <= 0; out_addr holds its value.
- Pending update each edge: pending <= (pending & ~clear_mask) | (req_valid ? req_vec : 0).
  - Set wins over clear for the same bit. A re-request of the bit being issued re-pends it.
- Duplicate requests for a bit already pending merge into one issue. There is no counting.
- Latency: request sampled at edge k. out_valid asserted after edge k+1 if the output stage is free. No combinational path from req_vec to out_*.
- Throughput: one address per cycle while out_ready=1 and pending is nonzero.
- Backpressure: while out_valid & ~out_ready, out_addr and out_valid hold stable and rr_ptr is frozen. New requests still accumulate.
- flush: highest priority after reset. On the edge, pending=0 and out_valid=0, and req_vec in that same cycle is discarded. rr_ptr is unchanged.
- Reset asserted mid-operation: all state clears immediately. No address is issued after reset deasserts until a new request arrives.
- Starvation-free: any pending bit is issued within 2**Bits accepted transfers.

Optional Feature:
- Macro: RF_ZERO_MASK_EN.
- Defined: req_vec[0] is masked before entering pending, so register 0 (hardwired zero) is never issued. pending[0] is constantly 0.
- Undefined: bit 0 is treated like every other bit.

Decomposition:
- Shared package rf_pkg:
  - RF_BITS=5, RF_REGS=32.
  - typedef rf_addr_t (RF_BITS wide).
  - typedef rf_vec_t (RF_REGS wide).
  - Shared with the decoder and register file.
- One sub-module, rr_pick: a combinational rotate / priority-encode / un-rotate.
  - Inputs: vec, ptr.
  - Outputs: idx, found.
  - Reusable by the read-port arbiter.

Test Plan:
- After reset: req_valid=1, req_vec=32'h0000_0001, out_ready=1. Expect out_valid=1, out_addr=0 one cycle later. Then pending=0, busy=0. With RF_ZERO_MASK_EN defined, out_valid stays 0.
- req_vec=32'h8000_0011, out_ready=1, rr_ptr=0. Expect addresses 0, 4, 31 on consecutive cycles. rr_ptr then equals 0 via wrap.
- Backpressure: out_ready=0 for 5 cycles while req_vec=32'h0000_0300 arrives. out_addr stays stable and pending=32'h300. Release out_ready; expect 8 then 9.
- Set-over-clear: with pending=32'h4 and bit 2 being issued this cycle, re-assert req_vec=32'h4. Expect address 2 to be issued twice.
- flush during a burst: pending=32'hFF, out_valid=1, and req_vec=32'h100 in the same cycle. Expect pending=0, out_valid=0 next cycle. Address 8 is never issued.
- Async reset mid-stream: pull rst_n low between clock edges. Outputs go to 0 immediately, without waiting for an edge.
